// File: rtl/finger_gesture_classifier.sv
// Finger gesture classifier: smooths per-frame dark-pixel coverage over four frames,
// quantises it to a finger level 0..5 and debounces across frames before committing.
`timescale 1ns/1ps

// state   | meaning
// S_FILL  | window filling after reset or timeout, no classification
// S_TRACK | window full, classification and debounce active
module finger_gesture_classifier #(
    parameter int unsigned FRAME_PIXELS   = 153600,
    parameter int unsigned STABLE_FRAMES  = 3,
    parameter int unsigned TH1            = 100,
    parameter int unsigned TH2            = 200,
    parameter int unsigned TH3            = 300,
    parameter int unsigned TH4            = 400,
    parameter int unsigned TH5            = 500,
    parameter int unsigned TIMEOUT_CYCLES = 307200
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [17:0] addr,
    input  logic [10:0] detect,
    output logic [2:0]  gesture,
    output logic        gesture_valid,
    output logic        gesture_change,
    output logic [10:0] avg_cov
);

    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [17:0] LAST_PIX = 18'(FRAME_PIXELS - 1);
    localparam logic [2:0]  SF       = 3'(STABLE_FRAMES);

    typedef enum logic {S_FILL, S_TRACK} state_t;

    state_t            state_q, state_d;
    logic [17:0]       addr_q;
    logic [3:0][10:0]  win_q, win_d;
    logic [12:0]       sum_q, sum_d;
    logic [2:0]        fill_q, fill_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic [10:0]       avg_q, avg_d;
    logic [2:0]        level_q, level_d;
    logic [2:0]        cand_q, cand_d, cand_n;
    logic [2:0]        stab_q, stab_d, stab_n;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [2:0]        gesture_q, gesture_d;
    logic              gv_q, gv_d;
    logic              gc_q, gc_d;
    logic              tick;
    logic              timeout;

    function automatic logic [2:0] level_of(input logic [10:0] a);
        level_of = 3'(a >= 11'(TH1)) + 3'(a >= 11'(TH2)) + 3'(a >= 11'(TH3))
                 + 3'(a >= 11'(TH4)) + 3'(a >= 11'(TH5));
    endfunction

    assign tick    = (addr == 18'd0) && (addr_q == LAST_PIX);
    // A tick in the same cycle always takes precedence over the timeout.
    assign timeout = !tick && (to_cnt_q == TO_MAX);

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        sum_d      = sum_q;
        fill_d     = fill_q;
        s1_valid_d = tick;
        s2_valid_d = 1'b0;
        avg_d      = avg_q;
        level_d    = level_q;
        cand_n     = cand_q;
        stab_n     = stab_q;
        cand_d     = cand_q;
        stab_d     = stab_q;
        gesture_d  = gesture_q;
        gv_d       = gv_q;
        gc_d       = 1'b0;
        to_cnt_d   = to_cnt_q;

        if (tick) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (tick) begin
            win_d = {win_q[2:0], detect};
            sum_d = sum_q + 13'(detect) - 13'(win_q[3]);
            if (fill_q != 3'd4) begin
                fill_d = fill_q + 3'd1;
            end
            if (fill_q == 3'd3) begin
                state_d = S_TRACK;
            end
        end

        if (s1_valid_q) begin
            avg_d      = sum_q[12:2];
            level_d    = level_of(sum_q[12:2]);
            s2_valid_d = (state_q == S_TRACK);
        end

        if (s2_valid_q) begin
            if (level_q == cand_q) begin
                stab_n = (stab_q == SF) ? SF : stab_q + 3'd1;
            end else begin
                cand_n = level_q;
                stab_n = 3'd1;
            end
            cand_d = cand_n;
            stab_d = stab_n;
            if ((stab_n == SF) && (!gv_q || (cand_n != gesture_q))) begin
                gesture_d = cand_n;
                gv_d      = 1'b1;
                gc_d      = 1'b1;
            end
        end

        // Lost frame stream: drop the track but keep the last gesture value visible.
        if (timeout) begin
            state_d    = S_FILL;
            win_d      = '0;
            sum_d      = '0;
            fill_d     = '0;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            cand_d     = '0;
            stab_d     = '0;
            gv_d       = 1'b0;
            gc_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_FILL;
            addr_q     <= '0;
            win_q      <= '0;
            sum_q      <= '0;
            fill_q     <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            avg_q      <= '0;
            level_q    <= '0;
            cand_q     <= '0;
            stab_q     <= '0;
            to_cnt_q   <= '0;
            gesture_q  <= '0;
            gv_q       <= 1'b0;
            gc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr;
            win_q      <= win_d;
            sum_q      <= sum_d;
            fill_q     <= fill_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            avg_q      <= avg_d;
            level_q    <= level_d;
            cand_q     <= cand_d;
            stab_q     <= stab_d;
            to_cnt_q   <= to_cnt_d;
            gesture_q  <= gesture_d;
            gv_q       <= gv_d;
            gc_q       <= gc_d;
        end
    end

    assign gesture        = gesture_q;
    assign gesture_valid  = gv_q;
    assign gesture_change = gc_q;
    assign avg_cov        = avg_q;

endmodule

// File: tb/tb_finger_gesture_classifier.sv
// Scoreboard bench for finger_gesture_classifier: directed frames push expected commits,
// a monitor pops and checks them whenever gesture_change pulses.
`timescale 1ns/1ps

module tb_finger_gesture_classifier;

    localparam int FP = 153600;
    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        rstn;
    logic [17:0] addr;
    logic [10:0] detect;
    logic [2:0]  gesture;
    logic        gesture_valid;
    logic        gesture_change;
    logic [10:0] avg_cov;

    typedef struct {
        int cyc;
        int lvl;
        int avg;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_tick = 0;

    finger_gesture_classifier #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .addr           (addr),
        .detect         (detect),
        .gesture        (gesture),
        .gesture_valid  (gesture_valid),
        .gesture_change (gesture_change),
        .avg_cov        (avg_cov)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (gesture_change !== 1'b0) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got gesture=%0d avg=%0d, expected no pulse (cycle %0d)",
                         gesture, avg_cov, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_gesture", int'(gesture), e.lvl);
                check("pulse_avg", int'(avg_cov), e.avg);
                check("pulse_valid", int'(gesture_valid), 1);
            end
        end
    end

    // One frame: a genuine wrap FP-1 -> 0 carrying det; exp_lvl < 0 means no commit expected.
    task automatic frame(input int det, input int exp_lvl, input int exp_avg, input bit rst_after);
        exp_t e;
        @(negedge clk);
        addr   = 18'(FP - 1);
        detect = 11'h7ff;
        @(negedge clk);
        addr      = 18'd0;
        detect    = det[10:0];
        last_tick = cyc;
        if (exp_lvl >= 0) begin
            e.cyc = cyc + 3;
            e.lvl = exp_lvl;
            e.avg = exp_avg;
            q.push_back(e);
        end
        @(negedge clk);
        addr   = 18'd5000;
        detect = 11'h7ff;
        if (rst_after) begin
            rstn = 1'b0;
            @(negedge clk);
            check("rst_gesture", int'(gesture), 0);
            check("rst_valid", int'(gesture_valid), 0);
            check("rst_change", int'(gesture_change), 0);
            check("rst_avg", int'(avg_cov), 0);
            rstn = 1'b1;
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rstn   = 1'b0;
        addr   = 18'd0;
        detect = 11'd0;
        repeat (3) @(negedge clk);
        check("reset_gesture", int'(gesture), 0);
        check("reset_valid", int'(gesture_valid), 0);
        check("reset_change", int'(gesture_change), 0);
        check("reset_avg", int'(avg_cov), 0);
        rstn = 1'b1;

        // Fill with 250s: commit level 2 on the 6th tick.
        for (int i = 1; i <= 6; i++) frame(250, (i == 6) ? 2 : -1, 250, 1'b0);
        check("a_gesture", int'(gesture), 2);
        check("a_valid", int'(gesture_valid), 1);

        // Step to 550: averages 325, 400, 475 pass without commit; level 5 on the 6th.
        for (int i = 1; i <= 6; i++) frame(550, (i == 6) ? 5 : -1, 550, 1'b0);
        check("b_gesture", int'(gesture), 5);

        // Alternate 90/110: averages 435, 325, 210, 100, 100, 100 -> level 1, then quiet.
        for (int i = 1; i <= 26; i++) frame((i % 2) ? 90 : 110, (i == 6) ? 1 : -1, 100, 1'b0);
        check("c_gesture", int'(gesture), 1);
        check("c_avg", int'(avg_cov), 100);

        // Stall addr: track dropped TO cycles after the last tick, gesture held.
        while (cyc < last_tick + TO) @(negedge clk);
        check("to_valid_before", int'(gesture_valid), 1);
        @(negedge clk);
        check("to_valid_after", int'(gesture_valid), 0);
        check("to_gesture_held", int'(gesture), 1);
        repeat (20) @(negedge clk);
        check("to_valid_stays", int'(gesture_valid), 0);

        // Resume: window refills from empty, commit after 4+2 ticks.
        for (int i = 1; i <= 6; i++) frame(250, (i == 6) ? 2 : -1, 250, 1'b0);
        check("resume_valid", int'(gesture_valid), 1);

        // Sixth 550 tick would commit level 5; reset one cycle after it kills the pulse.
        for (int i = 1; i <= 5; i++) frame(550, -1, 0, 1'b0);
        frame(550, -1, 0, 1'b1);
        check("post_rst_valid", int'(gesture_valid), 0);
        for (int i = 1; i <= 6; i++) frame(400, (i == 6) ? 4 : -1, 400, 1'b0);

        // addr 77 -> 0 is not a wrap: window must stay all 400.
        @(negedge clk);
        addr   = 18'd77;
        detect = 11'h7ff;
        @(negedge clk);
        addr   = 18'd0;
        detect = 11'd1000;
        @(negedge clk);
        addr   = 18'd5000;
        detect = 11'h7ff;
        repeat (4) @(negedge clk);
        check("fake_avg", int'(avg_cov), 400);
        frame(100, -1, 0, 1'b0);
        check("after_fake_avg", int'(avg_cov), 325);
        check("after_fake_gesture", int'(gesture), 4);

        repeat (10) @(negedge clk);
        check("pending_pulses", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
